// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator-side controller for the ALU ACT/RDY/VLD handshake.
//   - Accepts one operation per req_valid/req_ready handshake.
//   - Latches the opcode, select, operands and tag, and keeps them stable on the ALU buses.
//   - Raises alu_act until the ALU reports rdy.
//   - Collects one VLD word, or two words (low, then high) for MUL.
//   - Offers the assembled result to writeback with valid/ready backpressure.
//   - A per-word watchdog aborts a hung ALU. A sticky flag records stray VLD pulses.
//
// Ports
//   CLK, RST                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_op, req_movi             opcode (4'b0010 = MUL) and operand-B select
//   req_a/b/mem/imm, req_tag     operand sources and destination tag
//   alu_act                      ALU start, high throughout ISSUE
//   alu_op, alu_movi             latched opcode and select
//   alu_reg_a/b, alu_mem/imm     latched operands
//   alu_rdy, alu_vld, alu_data   ALU idle, result word valid, result word
//   wb_valid/wb_ready            writeback handshake
//   wb_tag, wb_lo, wb_hi         result tag and result words (wb_hi = 0 unless MUL)
//   wb_wide                      result is 64-bit
//   err_timeout                  one-cycle pulse on watchdog abort
//   err_proto                    sticky: alu_vld seen outside a wait state
//   ops_done                     wrapping count of writeback handshakes
module alu_issue_ctrl #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [1:0]       req_movi,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [31:0]      req_mem,
  input  logic [31:0]      req_imm,
  input  logic [TAG_W-1:0] req_tag,
  output logic             alu_act,
  output logic [3:0]       alu_op,
  output logic [1:0]       alu_movi,
  output logic [31:0]      alu_reg_a,
  output logic [31:0]      alu_reg_b,
  output logic [31:0]      alu_mem,
  output logic [31:0]      alu_imm,
  input  logic             alu_rdy,
  input  logic             alu_vld,
  input  logic [31:0]      alu_data,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_lo,
  output logic [31:0]      wb_hi,
  output logic             wb_wide,
  output logic             err_timeout,
  output logic             err_proto,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_LO = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  localparam logic [3:0] OP_MUL = 4'b0010;

  localparam int              WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [1:0]       movi_q, movi_d;
  logic [31:0]      a_q, a_d, b_q, b_d, mem_q, mem_d, imm_q, imm_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             wide_q, wide_d;
  logic [31:0]      lo_q, lo_d, hi_q, hi_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             tmo_q, tmo_d;
  logic             proto_q, proto_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    movi_d  = movi_q;
    a_d     = a_q;
    b_d     = b_q;
    mem_d   = mem_q;
    imm_d   = imm_q;
    tag_d   = tag_q;
    wide_d  = wide_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    wd_d    = wd_q;
    tmo_d   = 1'b0;
    proto_d = proto_q;
    cnt_d   = cnt_q;

    // A stray VLD is only flagged; it never moves the FSM or touches result data.
    if (alu_vld && (state_q == S_IDLE || state_q == S_ISSUE || state_q == S_OUT))
      proto_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          movi_d  = req_movi;
          a_d     = req_a;
          b_d     = req_b;
          mem_d   = req_mem;
          imm_d   = req_imm;
          tag_d   = req_tag;
          wide_d  = (req_op == OP_MUL);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (alu_rdy) begin
          wd_d    = '0;
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        // A VLD arriving in the final watchdog cycle still wins over the abort.
        if (alu_vld) begin
          lo_d = alu_data;
          if (wide_q) begin
            wd_d    = '0;
            state_d = S_WAIT_HI;
          end else begin
            hi_d    = '0;
            state_d = S_OUT;
          end
        end else if (wd_q == WD_MAX) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (alu_vld) begin
          hi_d    = alu_data;
          state_d = S_OUT;
        end else if (wd_q == WD_MAX) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_OUT: begin
        if (wb_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      movi_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mem_q   <= '0;
      imm_q   <= '0;
      tag_q   <= '0;
      wide_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
      proto_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      movi_q  <= movi_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mem_q   <= mem_d;
      imm_q   <= imm_d;
      tag_q   <= tag_d;
      wide_q  <= wide_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      proto_q <= proto_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign alu_act     = (state_q == S_ISSUE);
  assign wb_valid    = (state_q == S_OUT);
  assign alu_op      = op_q;
  assign alu_movi    = movi_q;
  assign alu_reg_a   = a_q;
  assign alu_reg_b   = b_q;
  assign alu_mem     = mem_q;
  assign alu_imm     = imm_q;
  assign wb_tag      = tag_q;
  assign wb_lo       = lo_q;
  assign wb_hi       = hi_q;
  assign wb_wide     = wide_q;
  assign err_timeout = tmo_q;
  assign err_proto   = proto_q;
  assign ops_done    = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl (TIMEOUT = 8). The bench plays the ALU by hand.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at the same point.
module tb_alu_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [1:0]  req_movi;
  logic [31:0] req_a, req_b, req_mem, req_imm;
  logic [4:0]  req_tag;
  logic        alu_act;
  logic [3:0]  alu_op;
  logic [1:0]  alu_movi;
  logic [31:0] alu_reg_a, alu_reg_b, alu_mem, alu_imm;
  logic        alu_rdy, alu_vld;
  logic [31:0] alu_data;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_tag;
  logic [31:0] wb_lo, wb_hi;
  logic        wb_wide, err_timeout, err_proto;
  logic [15:0] ops_done;

  int n_chk  = 0;
  int n_fail = 0;

  alu_issue_ctrl #(.TAG_W(5), .TIMEOUT(8), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_movi(req_movi),
    .req_a(req_a), .req_b(req_b), .req_mem(req_mem), .req_imm(req_imm), .req_tag(req_tag),
    .alu_act(alu_act), .alu_op(alu_op), .alu_movi(alu_movi),
    .alu_reg_a(alu_reg_a), .alu_reg_b(alu_reg_b), .alu_mem(alu_mem), .alu_imm(alu_imm),
    .alu_rdy(alu_rdy), .alu_vld(alu_vld), .alu_data(alu_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
    .wb_lo(wb_lo), .wb_hi(wb_hi), .wb_wide(wb_wide),
    .err_timeout(err_timeout), .err_proto(err_proto), .ops_done(ops_done)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic request(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_movi  = 2'b01;
    req_a     = a;
    req_b     = b;
    req_mem   = 32'h1000;
    req_imm   = 32'h0042;
    req_tag   = tag;
  endtask

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_op = '0; req_movi = '0;
    req_a = '0; req_b = '0; req_mem = '0; req_imm = '0; req_tag = '0;
    alu_rdy = 1'b0; alu_vld = 1'b0; alu_data = '0; wb_ready = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_alu_act", alu_act, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_err_proto", err_proto, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_alu_reg_a", alu_reg_a, 0);
    RST = 1'b0;
    tick();

    // ADD: 5 + 7, tag 3
    request(4'd0, 32'd5, 32'd7, 5'd3);
    alu_rdy = 1'b1; wb_ready = 1'b1;
    tick();                                   // ISSUE
    req_valid = 1'b0;
    chk("add_act_issue", alu_act, 1);
    chk("add_req_ready_issue", req_ready, 0);
    chk("add_reg_a", alu_reg_a, 5);
    chk("add_reg_b", alu_reg_b, 7);
    chk("add_movi", alu_movi, 2'b01);
    chk("add_imm", alu_imm, 32'h42);
    chk("add_wbv_issue", wb_valid, 0);
    tick();                                   // WAIT_LO
    chk("add_act_wait", alu_act, 0);
    chk("add_wbv_wait", wb_valid, 0);
    alu_vld = 1'b1; alu_data = 32'd12;
    tick();                                   // OUT
    alu_vld = 1'b0;
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_lo", wb_lo, 12);
    chk("add_wb_hi", wb_hi, 0);
    chk("add_wb_wide", wb_wide, 0);
    chk("add_wb_tag", wb_tag, 3);
    tick();                                   // IDLE
    chk("add_ops_done", ops_done, 1);
    chk("add_req_ready_after", req_ready, 1);
    chk("add_wbv_after", wb_valid, 0);

    // MUL with writeback backpressure
    request(4'b0010, 32'hFFFF_FFFF, 32'd2, 5'd9);
    wb_ready = 1'b0;
    tick();                                   // ISSUE
    req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'h0BAD_F00D;
    chk("mul_act_issue", alu_act, 1);
    chk("mul_op", alu_op, 4'b0010);
    tick();                                   // WAIT_LO
    chk("mul_act_once", alu_act, 0);
    chk("mul_reg_a_lo", alu_reg_a, 32'hFFFF_FFFF);
    alu_vld = 1'b1; alu_data = 32'hFFFF_FFFE;
    tick();                                   // WAIT_HI
    chk("mul_wbv_hi", wb_valid, 0);
    chk("mul_act_hi", alu_act, 0);
    chk("mul_reg_a_hi", alu_reg_a, 32'hFFFF_FFFF);
    chk("mul_reg_b_hi", alu_reg_b, 2);
    alu_data = 32'h0000_0001;
    tick();                                   // OUT
    alu_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_wb_valid", wb_valid, 1);
      chk("bp_wb_lo", wb_lo, 32'hFFFF_FFFE);
      chk("bp_wb_hi", wb_hi, 32'h1);
      chk("bp_wb_wide", wb_wide, 1);
      chk("bp_wb_tag", wb_tag, 9);
      chk("bp_req_ready", req_ready, 0);
      tick();
    end
    chk("bp_still_valid", wb_valid, 1);
    chk("bp_ops_held", ops_done, 1);
    wb_ready = 1'b1;
    tick();                                   // IDLE
    chk("mul_ops_done", ops_done, 2);
    chk("mul_req_ready_after", req_ready, 1);
    chk("mul_wbv_after", wb_valid, 0);
    chk("proto_clean", err_proto, 0);

    // ALU busy for 3 cycles in ISSUE
    request(4'd1, 32'd3, 32'd4, 5'd1);
    alu_rdy = 1'b0;
    tick();                                   // ISSUE, cycle 1
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("busy_act", alu_act, 1);
      tick();
    end
    chk("busy_act_4th", alu_act, 1);          // rdy seen at the end of this cycle
    alu_rdy = 1'b1;
    tick();                                   // WAIT_LO
    chk("busy_act_drop", alu_act, 0);
    alu_vld = 1'b1; alu_data = 32'h77;
    tick();                                   // OUT
    alu_vld = 1'b0;
    chk("busy_wb_lo", wb_lo, 32'h77);
    chk("busy_wb_tag", wb_tag, 1);
    tick();
    chk("busy_ops_done", ops_done, 3);

    // Timeout: no VLD for 8 wait cycles
    request(4'd0, 32'd1, 32'd1, 5'd4);
    tick();                                   // ISSUE
    req_valid = 1'b0;
    tick();                                   // WAIT_LO, wait cycle 1
    for (int i = 0; i < 7; i++) begin
      chk("tmo_no_pulse", err_timeout, 0);
      tick();
    end
    chk("tmo_still_waiting", req_ready, 0);   // wait cycle 8
    tick();
    chk("tmo_pulse", err_timeout, 1);
    chk("tmo_idle", req_ready, 1);
    chk("tmo_no_wb", wb_valid, 0);
    chk("tmo_ops_same", ops_done, 3);
    tick();
    chk("tmo_pulse_end", err_timeout, 0);

    // VLD on the 8th wait cycle wins
    request(4'd0, 32'd2, 32'd2, 5'd5);
    tick();
    req_valid = 1'b0;
    tick();                                   // wait cycle 1
    for (int i = 0; i < 7; i++) tick();       // wait cycle 8
    alu_vld = 1'b1; alu_data = 32'hABC;
    tick();
    alu_vld = 1'b0;
    chk("late_no_tmo", err_timeout, 0);
    chk("late_wb_valid", wb_valid, 1);
    chk("late_wb_lo", wb_lo, 32'hABC);
    tick();
    chk("late_ops_done", ops_done, 4);

    // Spurious VLD in IDLE
    alu_vld = 1'b1; alu_data = 32'h5555;
    tick();
    alu_vld = 1'b0;
    chk("proto_set", err_proto, 1);
    chk("proto_state_idle", req_ready, 1);
    chk("proto_lo_untouched", wb_lo, 32'hABC);

    // MUL, then reset in WAIT_HI
    request(4'b0010, 32'd6, 32'd7, 5'd2);
    tick();                                   // ISSUE
    req_valid = 1'b0;
    tick();                                   // WAIT_LO
    alu_vld = 1'b1; alu_data = 32'd42;
    tick();                                   // WAIT_HI
    alu_vld = 1'b0;
    chk("proto_sticky", err_proto, 1);
    chk("rst_mid_wait", req_ready, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst2_req_ready", req_ready, 1);
    chk("rst2_wb_valid", wb_valid, 0);
    chk("rst2_err_proto", err_proto, 0);
    chk("rst2_ops_done", ops_done, 0);
    chk("rst2_err_timeout", err_timeout, 0);
    chk("rst2_wb_wide", wb_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
